// File: rtl/sram_fifo_ctrl_128x44.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl_128x44
//
// Streaming FIFO controller wrapped around a 128 x 44-bit one-write/one-read
// SRAM macro. Words pushed over a valid/ready input are written through the
// macro's port 0, read back through port 1 and handed out in order from a
// 2-entry output buffer. Capacity is 130 words (128 in SRAM + 2 buffered).
//
// Optional feature macro: SRAM_FIFO_AFULL_EN
//   When defined, adds the AFULL_THRESH parameter and a registered
//   almost_full output (level >= AFULL_THRESH). When undefined, the port and
//   its logic are absent and everything else is identical.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The producer holds nothing hostage: ready never depends on valid, and
//   in_ready depends only on registered state (never on out_ready).
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     push interface (44-bit words)
//   out_valid/out_ready/out_data  pop interface, outputs are registers
//   level                 words held: mem_count + rd_inflight + ob_count
//   sram_csb0/wmask0/addr0/din0   macro write port (port 0), csb active low
//   sram_csb1/addr1/dout1         macro read port (port 1), csb active low
//   almost_full           level >= AFULL_THRESH (SRAM_FIFO_AFULL_EN only)
// ---------------------------------------------------------------------------
module sram_fifo_ctrl_128x44 #(
  parameter int DATA_WIDTH   = 44,
  parameter int ADDR_WIDTH   = 7,
  parameter int NUM_WMASKS   = 4
`ifdef SRAM_FIFO_AFULL_EN
  ,
  parameter int AFULL_THRESH = 120
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            level,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_FIFO_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      mem_count_q, mem_count_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            ob_count_q, ob_count_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;   // head entry, drives out_data
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;   // second entry
  logic                  out_valid_q, out_valid_d;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  logic       mem_full;
  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] credit;
  logic [1:0] cnt_after_pop;

  always_comb begin
    mem_full = (mem_count_q == CNT_W'(DEPTH));
    // Held low through reset so nothing is accepted while rst is asserted.
    in_ready = !rst && !mem_full;
    push     = in_valid && in_ready;
    pop      = out_valid_q && out_ready;
    // Free output slots not already claimed by an in-flight read; a pop in
    // this cycle frees one more. ob_count + rd_inflight never exceeds 2, so
    // this never underflows.
    credit   = 3'd2 - {1'b0, ob_count_q} - {2'b00, rd_inflight_q}
             + {2'b00, pop};
    issue    = (mem_count_q != '0) && (credit != 3'd0);
  end

  // -------------------------------------------------------------------------
  // Pointer / count next state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_count_d   = mem_count_q;
    rd_inflight_d = issue;

    // Pointers wrap naturally at 2**ADDR_WIDTH.
    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output buffer: ob0 is always the head. A pop shifts ob1 forward only if
  // it held a word, so an emptied buffer keeps showing the last head word.
  // The capture slot is chosen after the same-cycle pop is applied.
  // -------------------------------------------------------------------------
  always_comb begin
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;
    cnt_after_pop = ob_count_q - {1'b0, pop};

    if (pop && (ob_count_q == 2'd2)) ob0_d = ob1_q;

    if (rd_inflight_q) begin
      if (cnt_after_pop == 2'd0) ob0_d = sram_dout1;
      else                       ob1_d = sram_dout1;
    end

    ob_count_d  = cnt_after_pop + {1'b0, rd_inflight_q};
    out_valid_d = (ob_count_d != 2'd0);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      ob_count_q    <= 2'd0;
      ob0_q         <= '0;
      ob1_q         <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
      ob_count_q    <= ob_count_d;
      ob0_q         <= ob0_d;
      ob1_q         <= ob1_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid   = out_valid_q;
  assign out_data    = ob0_q;
  assign level       = 8'(mem_count_q) + {7'd0, rd_inflight_q}
                     + {6'd0, ob_count_q};

  // Write port: full-word writes only.
  assign sram_csb0   = !push;
  assign sram_wmask0 = {NUM_WMASKS{1'b1}};
  assign sram_addr0  = wr_ptr_q;
  assign sram_din0   = in_data;

  // Read port: a read needs mem_count > 0 and a write needs mem_count < 128,
  // so the two ports never address the same word in one cycle.
  assign sram_csb1   = !issue;
  assign sram_addr1  = rd_ptr_q;

`ifdef SRAM_FIFO_AFULL_EN
  logic [7:0] level_d;
  logic       almost_full_q, almost_full_d;

  always_comb begin
    level_d       = 8'(mem_count_d) + {7'd0, rd_inflight_d}
                  + {6'd0, ob_count_d};
    almost_full_d = (level_d >= 8'(AFULL_THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl_128x44.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl_128x44
//
// Bench for sram_fifo_ctrl_128x44 with a behavioural SRAM macro beside it.
// The reference model tracks the FIFO as three occupancy counters (words in
// SRAM, read in flight, words buffered) plus one data queue holding every
// accepted word in order; expected outputs are derived from those each
// cycle. Inputs change 1 time unit after posedge; outputs are compared at
// negedge. Build with +define+SRAM_FIFO_AFULL_EN to cover almost_full.
// ---------------------------------------------------------------------------
module tb_sram_fifo_ctrl_128x44;

  localparam int DW = 44;
  localparam int AW = 7;
  localparam int AFT = 120;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [7:0]    level;
  logic          sram_csb0;
  logic [3:0]    sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;
`ifdef SRAM_FIFO_AFULL_EN
  logic          almost_full;
`endif

  sram_fifo_ctrl_128x44 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef SRAM_FIFO_AFULL_EN
    , .almost_full(almost_full)
`endif
  );

  // Behavioural macro: write lanes by mask, read data appears after the edge
  // that samples the address.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      for (int l = 0; l < 4; l++)
        if (sram_wmask0[l]) mem[sram_addr0][l*11 +: 11] <= sram_din0[l*11 +: 11];
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  // -------------------------------------------------------------------------
  // Scoreboard / reference model
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_q[$];     // every accepted word not yet popped, in order
  int            m_mem = 0;    // words in SRAM
  int            m_fly = 0;    // read in flight (0/1)
  int            m_buf = 0;    // words in output buffer
  int            m_wp  = 0;
  int            m_rp  = 0;
  int            pops  = 0;
  logic [DW-1:0] last_head = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_mem = 0; m_fly = 0; m_buf = 0; m_wp = 0; m_rp = 0;
      last_head = '0;
    end else begin
      int  cr;
      bit  p_push, p_pop, p_iss;
      p_push = in_valid && (m_mem < 128);
      p_pop  = (m_buf > 0) && out_ready;
      cr     = 2 - m_buf - m_fly + (p_pop ? 1 : 0);
      p_iss  = (m_mem > 0) && (cr > 0);
      if (p_push) begin
        exp_q.push_back(in_data);
        m_wp = (m_wp + 1) % 128;
      end
      if (p_pop) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (p_iss) m_rp = (m_rp + 1) % 128;
      m_buf = m_buf - (p_pop ? 1 : 0) + m_fly;
      m_fly = p_iss ? 1 : 0;
      m_mem = m_mem + (p_push ? 1 : 0) - (p_iss ? 1 : 0);
      if (m_buf > 0) last_head = exp_q[0];
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      int lvl, cr;
      bit e_push, e_iss, e_pop;
      lvl    = m_mem + m_fly + m_buf;
      e_push = in_valid && (m_mem < 128);
      e_pop  = (m_buf > 0) && out_ready;
      cr     = 2 - m_buf - m_fly + (e_pop ? 1 : 0);
      e_iss  = (m_mem > 0) && (cr > 0);
      chk("level", level, lvl);
      chk("in_ready", in_ready, m_mem < 128);
      chk("out_valid", out_valid, m_buf > 0);
      chk("out_data", out_data, (m_buf > 0) ? exp_q[0] : last_head);
      chk("csb0", sram_csb0, !e_push);
      chk("csb1", sram_csb1, !e_iss);
      if (e_push) begin
        chk("addr0", sram_addr0, m_wp);
        chk("din0", sram_din0, in_data);
        chk("wmask0", sram_wmask0, 4'hF);
      end
      if (e_iss) chk("addr1", sram_addr1, m_rp);
      chk("rw_collision", !sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1), 0);
`ifdef SRAM_FIFO_AFULL_EN
      chk("almost_full", almost_full, lvl >= AFT);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b1;   // must be ignored while in reset
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
`ifdef SRAM_FIFO_AFULL_EN
    chk("rst_almost_full", almost_full, 0);
`endif
    repeat (3) @(posedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    next_cyc();
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic push_word(input logic [DW-1:0] d);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      next_cyc();
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int seen, p0, cyc;
    logic [DW-1:0] seen_d;

    do_reset();

    // 1: single word latency and level trace.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 44'h0AB_CDEF_1234;
    @(negedge clk);
    chk("t1_csb0", sram_csb0, 0);
    chk("t1_wmask", sram_wmask0, 4'hF);
    chk("t1_level_n", level, 0);
    next_cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_level", level, 1);
      chk("t1_out_valid", out_valid, k == 3);
      if (k == 3) chk("t1_out_data", out_data, 44'h0AB_CDEF_1234);
      next_cyc();
    end
    @(negedge clk);
    chk("t1_level_end", level, 0);
    chk("t1_hold_data", out_data, 44'h0AB_CDEF_1234);
    chk("t1_valid_end", out_valid, 0);

    // 2: fill to 130 with out_ready low, then drain.
    do_reset();
    for (int w = 0; w < 130; w++) push_word(44'(w));
    in_valid = 1'b1;
    in_data  = 44'd130;
    repeat (4) next_cyc();
    @(negedge clk);
    chk("t2_level_full", level, 130);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_head", out_data, 0);
    next_cyc();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    repeat (140) next_cyc();
    chk("t2_drained", pops - p0, 130);
    chk("t2_level_empty", level, 0);

    // 3: continuous streaming, pointers wrap, no gaps.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 44'(i);
      @(negedge clk);
      if (i >= 3) begin
        chk("t3_no_gap", out_valid, 1);
        chk("t3_data", out_data, 44'(i - 3));
      end
      next_cyc();
    end
    in_valid = 1'b0;
    repeat (6) next_cyc();
    chk("t3_level_end", level, 0);

    // 4: random traffic, 10k words out.
    do_reset();
    p0  = pops;
    cyc = 0;
    while ((pops - p0) < 10000 && cyc < 50000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 44'({$urandom(), $urandom()});
      out_ready = 1'($urandom_range(0, 1));
      next_cyc();
      cyc++;
    end
    chk("t4_enough_words", (pops - p0) >= 10000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (140) next_cyc();
    chk("t4_level_end", level, 0);

    // 5: reset with ~50 words stored and a read in flight.
    do_reset();
    for (int w = 0; w < 52; w++) push_word(44'(1000 + w));
    repeat (4) next_cyc();
    out_ready = 1'b1;          // one pop -> one read issued this cycle
    next_cyc();
    out_ready = 1'b0;
    chk("t5_level_pre", level, 51);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_level", level, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_csb0", sram_csb0, 1);
    chk("t5_csb1", sram_csb1, 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    next_cyc();
    in_valid  = 1'b1;
    in_data   = 44'h1;
    out_ready = 1'b1;
    next_cyc();
    in_valid = 1'b0;
    seen   = 0;
    seen_d = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++;
        seen_d = out_data;
      end
      next_cyc();
    end
    chk("t5_words_out", seen, 1);
    chk("t5_word", seen_d, 44'h1);

    // 6: level ramp with out_ready low (almost_full crossing at 120).
    do_reset();
    for (int j = 0; j < 125; j++) begin
      @(negedge clk);
      chk("t6_level", level, j);
`ifdef SRAM_FIFO_AFULL_EN
      chk("t6_afull", almost_full, j >= AFT);
`endif
      in_valid = 1'b1;
      in_data  = 44'(j);
      next_cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (140) next_cyc();
    chk("t6_level_end", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #900000;
    bad++;
    total++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
